decode_regfile: RTL and testbench

Decode stage that sits directly downstream of instruction fetch in the non-pipelined LEGv8 datapath. It takes the 32-bit fetched instruction and produces three things for the execute/branch logic:
- two 64-bit register operands from a 32-entry register file;
- the extended immediate for the instruction's format;
- the decoded field outputs.

The register file is written once per clock from the writeback path. X31 reads as zero (XZR).

---
 rtl/decode_regfile.sv | 105 ++++++++++
 tb/tb_decode_regfile.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// LEGv8 decode stage: 31 x WORD register file (X31 = XZR), field split and immediate extension; optional build macro REGFILE_BYPASS_EN.
// Latency: reads and immediate are combinational (0 cycles); writes land on the rising edge and are readable the next cycle.
// Backpressure: none; one writeback is accepted every cycle and reset clears the file with priority over a write.
module decode_regfile #(
    parameter int WORD      = 64,
    parameter int NUM_REGS  = 32,
    parameter int INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic                 reg2_loc,
    input  logic                 reg_write,
    input  logic [4:0]           write_reg,
    input  logic [WORD-1:0]      write_data,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2,
    output logic [WORD-1:0]      imm_ext,
    output logic [10:0]          opcode,
    output logic [4:0]           rd,
    output logic [5:0]           shamt
);

    localparam logic [4:0] XZR = 5'(NUM_REGS - 1);

    // XZR is not stored, so the array stops one short of NUM_REGS
    logic [WORD-1:0] regs [NUM_REGS-1];

    logic [4:0]      rn;
    logic [4:0]      rm;
    logic [4:0]      rt;
    logic [4:0]      r2;
    logic            wr_en;
    logic [WORD-1:0] imm;

    assign rn     = instruction[9:5];
    assign rm     = instruction[20:16];
    assign rt     = instruction[4:0];
    assign r2     = reg2_loc ? rt : rm;
    assign wr_en  = reg_write && (write_reg != XZR);

    assign opcode = instruction[31:21];
    assign rd     = instruction[4:0];
    assign shamt  = instruction[15:10];

    // Value seen by one read port; XZR is hard zero, optional same-cycle forwarding
    function automatic logic [WORD-1:0] port_value(input logic [4:0] idx);
        logic [WORD-1:0] v;
        v = '0;
        if (idx != XZR) begin
            v = regs[idx];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (write_reg == idx)) begin
                v = write_data;
            end
`endif
        end
        return v;
    endfunction

    // Register file update: reset clears everything and beats a simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Operand reads, held at zero while reset is asserted
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (!reset) begin
            read_data1 = port_value(rn);
            read_data2 = port_value(r2);
        end
    end

    // Immediate format selection, first matching format wins
    always_comb begin
        imm = '0;
        if (instruction[31:26] inside {6'h05, 6'h25}) begin
            imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
        end else if (instruction[31:24] inside {8'hB4, 8'hB5, 8'h54}) begin
            imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
        end else if (instruction[31:23] inside {9'h1A5, 9'h1E5}) begin
            // hw field selects a 16-bit lane; shift amount is 16*hw
            imm = {{(WORD-16){1'b0}}, instruction[20:5]} << {instruction[22:21], 4'b0000};
        end else if (instruction[31:21] inside {11'h7C0, 11'h7C2}) begin
            imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
        end else if (instruction[31:22] inside {10'h244, 10'h248, 10'h2C4, 10'h2C8,
                                                10'h344, 10'h348, 10'h3C4, 10'h3C8}) begin
            imm = {{(WORD-12){1'b0}}, instruction[21:10]};
        end
    end

    // Immediate is also held at zero during reset
    always_comb begin
        imm_ext = reset ? '0 : imm;
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Testbench for decode_regfile: directed test-plan cases then randomized traffic.
// Driver pushes expected outputs from a behavioural model; monitor pops and compares each cycle.
// Build with +define+REGFILE_BYPASS_EN to check the forwarding configuration.
module tb_decode_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        reg2_loc;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [63:0] read_data1;
    logic [63:0] read_data2;
    logic [63:0] imm_ext;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [5:0]  shamt;

    decode_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .reg2_loc    (reg2_loc),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .imm_ext     (imm_ext),
        .opcode      (opcode),
        .rd          (rd),
        .shamt       (shamt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [10:0] op;
        logic [4:0]  rdf;
        logic [5:0]  sh;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem [32];
    int          n_cmp  = 0;
    int          n_fail = 0;

    // ---------------- behavioural reference model ----------------
    function automatic logic [63:0] sext(input logic [63:0] f, input int n);
        longint v;
        v = longint'(f);
        if (f[n-1]) v = v - (longint'(1) << n);
        return 64'(v);
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ins);
        if (ins[31:26] == 6'h05 || ins[31:26] == 6'h25)
            return sext(64'(ins[25:0]), 26);
        if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54)
            return sext(64'(ins[23:5]), 19);
        if (ins[31:23] == 9'h1A5 || ins[31:23] == 9'h1E5)
            return 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
        if (ins[31:21] == 11'h7C0 || ins[31:21] == 11'h7C2)
            return sext(64'(ins[20:12]), 9);
        if (ins[31:22] inside {10'h244, 10'h248, 10'h2C4, 10'h2C8,
                               10'h344, 10'h348, 10'h3C4, 10'h3C8})
            return 64'(ins[21:10]);
        return 64'd0;
    endfunction

    function automatic logic [63:0] model_rd(input logic [4:0] idx);
        if (reset) return 64'd0;
        if (idx == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == idx) return write_data;
`endif
        return mem[idx];
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of inputs; kr/ki replace model reads/immediate by fixed test-plan values
    task automatic step(input logic [31:0] ins, input logic r2l, input logic rst,
                        input logic rw, input logic [4:0] wreg, input logic [63:0] wdat,
                        input bit kr, input logic [63:0] k1, input logic [63:0] k2,
                        input bit ki, input logic [63:0] kimm);
        exp_t e;
        instruction = ins;
        reg2_loc    = r2l;
        reset       = rst;
        reg_write   = rw;
        write_reg   = wreg;
        write_data  = wdat;
        e.rd1 = kr ? k1 : model_rd(ins[9:5]);
        e.rd2 = kr ? k2 : model_rd(r2l ? ins[4:0] : ins[20:16]);
        e.imm = rst ? 64'd0 : (ki ? kimm : model_imm(ins));
        e.op  = ins[31:21];
        e.rdf = ins[4:0];
        e.sh  = ins[15:10];
        sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        end else if (rw && wreg != 5'd31) begin
            mem[wreg] = wdat;
        end
        #1;
    endtask

    task automatic mstep(input logic [31:0] ins, input logic r2l, input logic rst,
                         input logic rw, input logic [4:0] wreg, input logic [63:0] wdat);
        step(ins, r2l, rst, rw, wreg, wdat, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    endtask

    function automatic logic [31:0] rrr(input logic [4:0] rm_i, input logic [4:0] rn_i,
                                        input logic [4:0] rt_i);
        return {11'h458, rm_i, 6'd0, rn_i, rt_i};
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("read_data1", read_data1, e.rd1);
            chk("read_data2", read_data2, e.rd2);
            chk("imm_ext",    imm_ext,    e.imm);
            chk("opcode",     64'(opcode), 64'(e.op));
            chk("rd",         64'(rd),     64'(e.rdf));
            chk("shamt",      64'(shamt),  64'(e.sh));
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [9:0] I_OPS [8] = '{10'h244, 10'h248, 10'h2C4, 10'h2C8,
                                         10'h344, 10'h348, 10'h3C4, 10'h3C8};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h25 : 6'h05;
            1: begin
                case ($urandom_range(0, 2))
                    0:       r[31:24] = 8'hB4;
                    1:       r[31:24] = 8'hB5;
                    default: r[31:24] = 8'h54;
                endcase
            end
            2: r[31:23] = ($urandom_range(0, 1) == 1) ? 9'h1E5 : 9'h1A5;
            3: r[31:21] = ($urandom_range(0, 1) == 1) ? 11'h7C2 : 11'h7C0;
            4: r[31:22] = I_OPS[$urandom_range(0, 7)];
            default: ;
        endcase
        return r;
    endfunction

    logic [63:0] raw_same;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        instruction = 32'd0;
        reg2_loc    = 1'b0;
        reg_write   = 1'b0;
        write_reg   = 5'd0;
        write_data  = 64'd0;
        reset       = 1'b1;
        @(posedge clk);
        #1;

        // Reset forces operands and immediate to zero (B instruction with nonzero imm)
        step({6'h05, 26'h3FFFFFF}, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b1, 64'd0);

        // Reset clears a previously written X5
        mstep(32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        step(rrr(5'd5, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 64'd0);
        step(rrr(5'd5, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);
        step(rrr(5'd5, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);

        // XZR: write to 31 is dropped and both ports read zero
        step(rrr(5'd31, 5'd31, 5'd31), 1'b0, 1'b0, 1'b1, 5'd31, 64'h1234,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);
        step(rrr(5'd31, 5'd31, 5'd31), 1'b1, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);
        step(rrr(5'd5, 5'd0, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);

        // Read-after-write on X9, both ports addressing the same index
`ifdef REGFILE_BYPASS_EN
        raw_same = 64'hA5;
`else
        raw_same = 64'd0;
`endif
        step(rrr(5'd9, 5'd9, 5'd9), 1'b0, 1'b0, 1'b1, 5'd9, 64'hA5,
             1'b1, raw_same, raw_same, 1'b0, 64'd0);
        step(rrr(5'd9, 5'd9, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'hA5, 64'hA5, 1'b0, 64'd0);

        // reg2_loc select between Rm=3 and Rt=7
        mstep(32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 64'd30);
        mstep(32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 64'd70);
        step(rrr(5'd3, 5'd3, 5'd7), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd30, 64'd30, 1'b0, 64'd0);
        step(rrr(5'd3, 5'd3, 5'd7), 1'b1, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd30, 64'd70, 1'b0, 64'd0);

        // Immediate formats with fixed expected values
        step({6'h05, 26'h3FFFFFF}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step({8'hB4, 19'h00010, 5'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'h10);
        step({11'h7C2, 9'h1F8, 2'b00, 5'd0, 5'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        step({10'h244, 12'hFFF, 5'd0, 5'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'hFFF);
        step({9'h1A5, 2'd2, 16'hBEEF, 5'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'h0000_BEEF_0000_0000);
        step({9'h1E5, 2'd3, 16'h8001, 5'd0}, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b0, 64'd0, 64'd0, 1'b1, 64'h8001_0000_0000_0000);

        // Reset beats a simultaneous write to X2
        mstep(32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 64'h11);
        mstep(rrr(5'd2, 5'd2, 5'd2), 1'b0, 1'b1, 1'b1, 5'd2, 64'h55);
        step(rrr(5'd2, 5'd2, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
             1'b1, 64'd0, 64'd0, 1'b0, 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            mstep(rand_instr(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)),
                  {$urandom, $urandom});
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
